// File: rtl/fc_layer_sequencer.sv
// Chains fully-connected layers through the FC engine: buffers each non-final
// layer's results, writes them back as the next ifmap, forwards final results.
module fc_layer_sequencer #(
   parameter int DATA_W    = 8,
   parameter int BUF_DEPTH = 128,
   parameter int PTR_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seq_start_i,
   input  logic [1:0]        layer_cnt_i,
   input  logic [8:0]        l0_in_num_i,
   input  logic [6:0]        l0_out_num_i,
   input  logic [6:0]        l1_out_num_i,
   input  logic [6:0]        l2_out_num_i,
   output logic              fc_start_o,
   output logic [8:0]        fc_in_node_num_o,
   output logic [6:0]        fc_out_node_num_o,
   output logic [1:0]        fc_nth_fully_o,
   output logic              ifmap_wren_o,
   output logic [PTR_W-1:0]  ifmap_wrptr_o,
   output logic [DATA_W-1:0] ifmap_wdata_o,
   input  logic [DATA_W-1:0] fc_result_i,
   input  logic              fc_valid_i,
   input  logic              fc_last_i,
   output logic [DATA_W-1:0] res_data_o,
   output logic              res_valid_o,
   output logic              res_last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_COLLECT,
      S_COPY,
      S_DONE
   } state_t;

   state_t state, state_d;

   logic [1:0]  lyr, lyr_d;
   logic [6:0]  cnt, cnt_d;
   logic [6:0]  prev_n, prev_n_d;
   logic [1:0]  cfg_lcnt, cfg_lcnt_d;
   logic [6:0]  cfg_out1, cfg_out1_d;
   logic [6:0]  cfg_out2, cfg_out2_d;

   logic              fc_start_d;
   logic [8:0]        in_num_d;
   logic [6:0]        out_num_d;
   logic [1:0]        nth_d;
   logic              wren_d;
   logic [PTR_W-1:0]  wrptr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] res_data_d;
   logic              res_valid_d;
   logic              res_last_d;
   logic              busy_d;
   logic              done_d;
   logic              err_d;

   logic [DATA_W-1:0] node_buf [BUF_DEPTH];
   logic              buf_we;

   logic [6:0] cnt_inc;
   logic [1:0] lyr_inc;
   logic       is_final;
   logic       reach_n;
   logic       beat_end;
   logic [6:0] next_out;

   always_comb begin
      cnt_inc  = cnt + 7'd1;
      lyr_inc  = lyr + 2'd1;
      is_final = ({1'b0, lyr} + 3'd1) >= {1'b0, cfg_lcnt};
      reach_n  = (cnt_inc == fc_out_node_num_o);
      beat_end = fc_last_i | reach_n;
      case (lyr_inc)
         2'd1:    next_out = cfg_out1;
         default: next_out = cfg_out2;
      endcase
   end

   always_comb begin
      state_d     = state;
      lyr_d       = lyr;
      cnt_d       = cnt;
      prev_n_d    = prev_n;
      cfg_lcnt_d  = cfg_lcnt;
      cfg_out1_d  = cfg_out1;
      cfg_out2_d  = cfg_out2;
      fc_start_d  = 1'b0;
      in_num_d    = fc_in_node_num_o;
      out_num_d   = fc_out_node_num_o;
      nth_d       = fc_nth_fully_o;
      wren_d      = 1'b0;
      wrptr_d     = ifmap_wrptr_o;
      wdata_d     = ifmap_wdata_o;
      res_data_d  = res_data_o;
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
      busy_d      = busy_o;
      done_d      = 1'b0;
      err_d       = err_o;
      buf_we      = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (seq_start_i) begin
               cfg_lcnt_d = (layer_cnt_i == 2'd0) ? 2'd1 : layer_cnt_i;
               cfg_out1_d = l1_out_num_i;
               cfg_out2_d = l2_out_num_i;
               lyr_d      = '0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               fc_start_d = 1'b1;
               nth_d      = '0;
               in_num_d   = l0_in_num_i;
               out_num_d  = l0_out_num_i;
               state_d    = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (fc_valid_i) begin
               cnt_d = cnt_inc;
               if (fc_last_i != reach_n) err_d = 1'b1;
               if (is_final) begin
                  res_valid_d = 1'b1;
                  res_data_d  = fc_result_i;
                  res_last_d  = beat_end;
               end else begin
                  buf_we = 1'b1;
               end
               if (beat_end) begin
                  cnt_d = '0;
                  if (is_final) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     // entry 0 may be the beat being written this very cycle
                     prev_n_d = cnt_inc;
                     wren_d   = 1'b1;
                     wrptr_d  = '0;
                     wdata_d  = (cnt == '0) ? fc_result_i : node_buf[0];
                     state_d  = S_COPY;
                  end
               end
            end
         end
         S_COPY: begin
            if (cnt_inc < prev_n) begin
               cnt_d   = cnt_inc;
               wren_d  = 1'b1;
               wrptr_d = PTR_W'(cnt_inc);
               wdata_d = node_buf[cnt_inc];
            end else begin
               lyr_d      = lyr_inc;
               fc_start_d = 1'b1;
               nth_d      = lyr_inc;
               in_num_d   = {2'b00, prev_n};
               out_num_d  = next_out;
               state_d    = S_START;
            end
         end
         S_DONE: begin
            busy_d    = 1'b0;
            in_num_d  = '0;
            out_num_d = '0;
            nth_d     = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (fc_valid_i && (state != S_COLLECT)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         lyr               <= '0;
         cnt               <= '0;
         prev_n            <= '0;
         cfg_lcnt          <= '0;
         cfg_out1          <= '0;
         cfg_out2          <= '0;
         fc_start_o        <= 1'b0;
         fc_in_node_num_o  <= '0;
         fc_out_node_num_o <= '0;
         fc_nth_fully_o    <= '0;
         ifmap_wren_o      <= 1'b0;
         ifmap_wrptr_o     <= '0;
         ifmap_wdata_o     <= '0;
         res_data_o        <= '0;
         res_valid_o       <= 1'b0;
         res_last_o        <= 1'b0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         state             <= state_d;
         lyr               <= lyr_d;
         cnt               <= cnt_d;
         prev_n            <= prev_n_d;
         cfg_lcnt          <= cfg_lcnt_d;
         cfg_out1          <= cfg_out1_d;
         cfg_out2          <= cfg_out2_d;
         fc_start_o        <= fc_start_d;
         fc_in_node_num_o  <= in_num_d;
         fc_out_node_num_o <= out_num_d;
         fc_nth_fully_o    <= nth_d;
         ifmap_wren_o      <= wren_d;
         ifmap_wrptr_o     <= wrptr_d;
         ifmap_wdata_o     <= wdata_d;
         res_data_o        <= res_data_d;
         res_valid_o       <= res_valid_d;
         res_last_o        <= res_last_d;
         busy_o            <= busy_d;
         done_o            <= done_d;
         err_o             <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) node_buf[cnt] <= fc_result_i;
   end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: an engine model returns index+layer
// per beat; a negedge monitor logs starts, ifmap writes and final results.
module tb_fc_layer_sequencer;

   localparam int DATA_W = 8;
   localparam int PTR_W  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              seq_start_i = 1'b0;
   logic [1:0]        layer_cnt_i = '0;
   logic [8:0]        l0_in_num_i = '0;
   logic [6:0]        l0_out_num_i = '0, l1_out_num_i = '0, l2_out_num_i = '0;
   logic              fc_start_o;
   logic [8:0]        fc_in_node_num_o;
   logic [6:0]        fc_out_node_num_o;
   logic [1:0]        fc_nth_fully_o;
   logic              ifmap_wren_o;
   logic [PTR_W-1:0]  ifmap_wrptr_o;
   logic [DATA_W-1:0] ifmap_wdata_o;
   logic [DATA_W-1:0] fc_result_i = '0;
   logic              fc_valid_i = 1'b0;
   logic              fc_last_i = 1'b0;
   logic [DATA_W-1:0] res_data_o;
   logic              res_valid_o, res_last_o, busy_o, done_o, err_o;

   fc_layer_sequencer #(.DATA_W(DATA_W), .BUF_DEPTH(128), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst), .seq_start_i(seq_start_i), .layer_cnt_i(layer_cnt_i),
      .l0_in_num_i(l0_in_num_i), .l0_out_num_i(l0_out_num_i),
      .l1_out_num_i(l1_out_num_i), .l2_out_num_i(l2_out_num_i),
      .fc_start_o(fc_start_o), .fc_in_node_num_o(fc_in_node_num_o),
      .fc_out_node_num_o(fc_out_node_num_o), .fc_nth_fully_o(fc_nth_fully_o),
      .ifmap_wren_o(ifmap_wren_o), .ifmap_wrptr_o(ifmap_wrptr_o),
      .ifmap_wdata_o(ifmap_wdata_o), .fc_result_i(fc_result_i),
      .fc_valid_i(fc_valid_i), .fc_last_i(fc_last_i), .res_data_o(res_data_o),
      .res_valid_o(res_valid_o), .res_last_o(res_last_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int lc; int in0; int o0; int o1; int o2;
      int gap; int early0; int nolast0;
      int exp_writes; int exp_res; int exp_err;
   } scen_t;

   int checks = 0;
   int errors = 0;

   int st_nth[$], st_in[$], st_out[$], st_cyc[$];
   int wr_ptr[$], wr_data[$], wr_cyc[$];
   int rs_data[$], rs_last[$];
   int done_cnt, done_cyc, done_last, done_busy;

   always @(negedge clk) begin
      if (!rst) begin
         if (fc_start_o) begin
            st_nth.push_back(int'(fc_nth_fully_o));
            st_in.push_back(int'(fc_in_node_num_o));
            st_out.push_back(int'(fc_out_node_num_o));
            st_cyc.push_back(cyc);
         end
         if (ifmap_wren_o) begin
            wr_ptr.push_back(int'(ifmap_wrptr_o));
            wr_data.push_back(int'(ifmap_wdata_o));
            wr_cyc.push_back(cyc);
         end
         if (res_valid_o) begin
            rs_data.push_back(int'(res_data_o));
            rs_last.push_back(int'(res_last_o));
         end
         if (done_o) begin
            done_cnt++;
            done_cyc  = cyc;
            done_last = int'(res_last_o);
            done_busy = int'(busy_o);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      st_nth.delete(); st_in.delete(); st_out.delete(); st_cyc.delete();
      wr_ptr.delete(); wr_data.delete(); wr_cyc.delete();
      rs_data.delete(); rs_last.delete();
      done_cnt = 0; done_cyc = 0; done_last = 0; done_busy = 0;
   endtask

   function automatic int outputs_nonzero();
      return int'({fc_start_o, fc_in_node_num_o, fc_out_node_num_o, fc_nth_fully_o,
                   ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o, res_data_o,
                   res_valid_o, res_last_o, busy_o, done_o, err_o} != '0);
   endfunction

   // Engine model: waits for a start, then returns beats of value index+layer.
   task automatic run_layer(input int gap, input int early, input int nolast,
                            input int seq_at, output int last_cyc);
      int n, l, cnt;
      bit seen;
      seen = 1'b0;
      last_cyc = 0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk);
         if (fc_start_o) seen = 1'b1;
      end
      if (!seen) begin
         check("start_timeout", 0, 1);
         return;
      end
      n   = int'(fc_out_node_num_o);
      l   = int'(fc_nth_fully_o);
      cnt = (early > 0) ? early : n;
      for (int i = 0; i < cnt; i++) begin
         @(posedge clk); #1;
         fc_valid_i  = 1'b1;
         fc_result_i = DATA_W'(i + l);
         fc_last_i   = (i == cnt - 1) && (nolast == 0);
         seq_start_i = (i == seq_at);
         last_cyc    = cyc;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            fc_valid_i = 1'b0; fc_last_i = 1'b0; seq_start_i = 1'b0;
         end
      end
      @(posedge clk); #1;
      fc_valid_i = 1'b0; fc_last_i = 1'b0; seq_start_i = 1'b0;
   endtask

   task automatic check_chain(input string tag, input scen_t s,
                              input int l0_last, input int last_beat);
      int lce, c[3], outs[3], eptr[$], edat[$], nmin;
      lce = (s.lc == 0) ? 1 : s.lc;
      c[0] = (s.early0 > 0) ? s.early0 : s.o0;
      c[1] = s.o1; c[2] = s.o2;
      outs[0] = s.o0; outs[1] = s.o1; outs[2] = s.o2;

      check({tag, "_n_starts"}, st_nth.size(), lce);
      for (int L = 0; L < lce && L < st_nth.size(); L++) begin
         check($sformatf("%s_nth%0d", tag, L), st_nth[L], L);
         check($sformatf("%s_in%0d", tag, L), st_in[L], (L == 0) ? s.in0 : c[L-1]);
         check($sformatf("%s_out%0d", tag, L), st_out[L], outs[L]);
      end

      for (int L = 0; L < lce - 1; L++)
         for (int i = 0; i < c[L]; i++) begin
            eptr.push_back(i);
            edat.push_back(i + L);
         end
      check({tag, "_n_writes"}, wr_ptr.size(), s.exp_writes);
      nmin = (wr_ptr.size() < eptr.size()) ? wr_ptr.size() : eptr.size();
      for (int i = 0; i < nmin; i++) begin
         check($sformatf("%s_wrptr%0d", tag, i), wr_ptr[i], eptr[i]);
         check($sformatf("%s_wdata%0d", tag, i), wr_data[i], edat[i]);
      end
      if (lce > 1 && wr_cyc.size() > 0)
         check({tag, "_copy_latency"}, wr_cyc[0] - l0_last, 1);
      if (lce > 1 && st_cyc.size() > 1 && wr_cyc.size() >= c[0])
         check({tag, "_restart_latency"}, st_cyc[1] - wr_cyc[c[0]-1], 1);

      check({tag, "_n_res"}, rs_data.size(), s.exp_res);
      for (int i = 0; i < rs_data.size() && i < c[lce-1]; i++) begin
         check($sformatf("%s_res%0d", tag, i), rs_data[i], i + lce - 1);
         check($sformatf("%s_rlast%0d", tag, i), rs_last[i], int'(i == c[lce-1] - 1));
      end

      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_latency"}, done_cyc - last_beat, 1);
      check({tag, "_last_at_done"}, done_last, 1);
      check({tag, "_busy_at_done"}, done_busy, 1);
      check({tag, "_err"}, int'(err_o), s.exp_err);
   endtask

   task automatic run_chain(input string tag, input scen_t s, input int stray,
                            input int seq_at);
      int lce, lc, l0_last, last_beat;
      bit seen;
      lce = (s.lc == 0) ? 1 : s.lc;
      l0_last = 0; last_beat = 0;
      clear_mon();
      @(posedge clk); #1;
      layer_cnt_i  = 2'(s.lc);
      l0_in_num_i  = 9'(s.in0);
      l0_out_num_i = 7'(s.o0);
      l1_out_num_i = 7'(s.o1);
      l2_out_num_i = 7'(s.o2);
      seq_start_i  = 1'b1;
      @(posedge clk); #1;
      seq_start_i  = 1'b0;
      for (int L = 0; L < lce; L++) begin
         run_layer(s.gap, (L == 0) ? s.early0 : 0, (L == 0) ? s.nolast0 : 0,
                   (L == lce - 1) ? seq_at : -1, lc);
         if (L == 0) l0_last = lc;
         last_beat = lc;
         if (L == 0 && stray != 0 && lce > 1) begin
            @(posedge clk); #1;
            fc_valid_i = 1'b1; fc_result_i = 8'hAA;
            @(posedge clk); #1;
            fc_valid_i = 1'b0;
         end
      end
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         if (done_cnt > 0) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) check({tag, "_done_timeout"}, 0, 1);
      @(negedge clk);
      check({tag, "_busy_after_done"}, int'(busy_o), 0);
      check_chain(tag, s, l0_last, last_beat);
   endtask

   scen_t tbl[6];
   scen_t sa, sb;
   int lc_tmp;

   initial begin
      tbl[0] = '{lc:3, in0:128, o0:84, o1:64, o2:10, gap:0, early0:0, nolast0:0, exp_writes:148, exp_res:10, exp_err:0};
      tbl[1] = '{lc:1, in0:20,  o0:10, o1:5,  o2:5,  gap:0, early0:0, nolast0:0, exp_writes:0,   exp_res:10, exp_err:0};
      tbl[2] = '{lc:2, in0:16,  o0:10, o1:7,  o2:5,  gap:0, early0:5, nolast0:0, exp_writes:5,   exp_res:7,  exp_err:1};
      tbl[3] = '{lc:2, in0:50,  o0:84, o1:3,  o2:5,  gap:2, early0:0, nolast0:0, exp_writes:84,  exp_res:3,  exp_err:0};
      tbl[4] = '{lc:0, in0:9,   o0:4,  o1:5,  o2:5,  gap:1, early0:0, nolast0:0, exp_writes:0,   exp_res:4,  exp_err:0};
      tbl[5] = '{lc:2, in0:10,  o0:5,  o1:3,  o2:5,  gap:0, early0:0, nolast0:1, exp_writes:5,   exp_res:3,  exp_err:1};
      sa     = '{lc:2, in0:8,   o0:6,  o1:4,  o2:5,  gap:0, early0:0, nolast0:0, exp_writes:6,   exp_res:4,  exp_err:1};
      sb     = '{lc:2, in0:12,  o0:8,  o1:3,  o2:5,  gap:0, early0:0, nolast0:0, exp_writes:8,   exp_res:3,  exp_err:0};

      repeat (2) @(negedge clk);
      check("reset_outputs", outputs_nonzero(), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int t = 0; t < 6; t++)
         run_chain($sformatf("vec%0d", t), tbl[t], 0, -1);

      // stray beat during COPY, seq_start during the final layer's COLLECT
      run_chain("stray", sa, 1, 1);

      // reset while COPY is in progress, then a clean 2-layer chain
      clear_mon();
      @(posedge clk); #1;
      layer_cnt_i = 2'd2; l0_in_num_i = 9'd12;
      l0_out_num_i = 7'd30; l1_out_num_i = 7'd5;
      seq_start_i = 1'b1;
      @(posedge clk); #1;
      seq_start_i = 1'b0;
      run_layer(0, 0, 0, -1, lc_tmp);
      repeat (3) @(posedge clk);
      #1;
      check("copy_active_before_rst", int'(ifmap_wren_o), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_copy_outputs", outputs_nonzero(), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_chain("after_rst", sb, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Chains consecutive fully-connected layers through the FC engine without host involvement. It consumes the engine's result stream (`fc_result`/`fc_valid`/`fc_last`), buffers one layer's output nodes, and writes them back through the engine's ifmap write port as the next layer's input. It then issues the next `start` with updated node counts and layer index. Results of the final layer are forwarded to the downstream consumer. The block sits between the FC engine top and the network-level controller.

## Interface
Parameters:
- `DATA_W`, 8, width of a node value
- `BUF_DEPTH`, 128, internal node buffer depth (must be ≥ max out-node count, 84)
- `PTR_W`, 10, width of the ifmap write pointer

Ports:
- `clk` in 1: single clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset
- `seq_start_i` in 1: one-cycle pulse; starts a chain. Layer-0 ifmap and all weights are already loaded.
- `layer_cnt_i` in 2: number of layers to run, 1..3. A value of 0 is treated as 1.
- `l0_in_num_i` in 9: layer-0 input node count, 1..128
- `l0_out_num_i`, `l1_out_num_i`, `l2_out_num_i` in 7 each: per-layer output node count, 1..84
- `fc_start_o` out 1: start pulse to the engine
- `fc_in_node_num_o` out 9, `fc_out_node_num_o` out 7, `fc_nth_fully_o` out 2: engine configuration
- `ifmap_wren_o` out 1, `ifmap_wrptr_o` out `PTR_W`, `ifmap_wdata_o` out `DATA_W`: engine ifmap write port
- `fc_result_i` in `DATA_W`, `fc_valid_i` in 1, `fc_last_i` in 1: engine result stream
- `res_data_o` out `DATA_W`, `res_valid_o` out 1, `res_last_o` out 1: final-layer output stream
- `busy_o` out 1: high from the cycle after `seq_start_i` until DONE exits
- `done_o` out 1: one-cycle pulse at chain completion
- `err_o` out 1: sticky protocol error, cleared only by `seq_start_i` or `rst`

## Operation
- States: IDLE → START → COLLECT → (COPY → START)* → DONE → IDLE.
- IDLE
  - `seq_start_i` latches all config inputs, sets layer index L=0, clears `err_o`, and moves to START.
  - `seq_start_i` in any other state is ignored.
- START (1 cycle)
  - `fc_start_o`=1.
  - `fc_nth_fully_o`=L.
  - `fc_in_node_num_o` = `l0_in_num` when L=0; otherwise the previous layer's out count.
  - `fc_out_node_num_o` = out count of layer L.
  - All four configuration outputs hold from START until the next START or IDLE.
  - Next state: COLLECT; the counter resets to 0.
- COLLECT: each `fc_valid_i` beat is handled as follows.
  - Non-final layer: write `fc_result_i` to `buf[cnt]`, then increment `cnt`.
  - Final layer: forward the beat to `res_*` with a 1-cycle register; nothing is buffered.
  - The layer ends when `fc_last_i` is seen or `cnt` reaches the out count N, whichever comes first.
  - `fc_last_i` with `cnt+1 ≠ N`, or reaching N without `fc_last_i`: set `err_o` and still end the layer.
  - On the final layer, `res_last_o` is forced on the beat that ends the layer.
  - Next state: COPY if L+1 < `layer_cnt`; otherwise DONE.
- COPY: one write per cycle for i = 0..N−1.
  - `ifmap_wren_o`=1, `ifmap_wrptr_o`=i, `ifmap_wdata_o`=`buf[i]`.
  - After the write at N−1, increment L and go to START.
- DONE (1 cycle): `done_o`=1, then IDLE.
- `fc_valid_i` outside COLLECT: the beat is dropped and `err_o` is set.
- Buffer: register array, combinational read. Pointer zero-extended to `PTR_W`.

## Timing
- Reset values: every output is 0. State = IDLE, L=0, `cnt`=0.
- Reset mid-operation returns to IDLE immediately; buffer contents become don't-care.
- All outputs are registered.
  - `seq_start_i` at cycle t → `fc_start_o` at t+1.
  - Final beat of a layer at t → first COPY write at t+1.
  - Last COPY write at t → `fc_start_o` at t+1.
- Final layer: `fc_valid_i` at t → `res_valid_o` at t+1.
  - The final beat at t gives `res_last_o`=`done_o`=1 at t+1, and `busy_o`=0 at t+2.
- The engine may deliver beats back-to-back or with gaps. No backpressure is applied on either side.

## Test plan
- 3 layers, in 128, outs 84/64/10, engine model produces `fc_result`=index+L:
  - expect ifmap writes 0..83 with data 0..83, then 0..63 with data 1..64;
  - expect three `fc_start_o` pulses, with `fc_nth_fully_o` 0/1/2 and `fc_in_node_num_o` 128/84/64;
  - expect 10 `res_valid_o` beats, data 2..11, `res_last_o` and `done_o` on beat 10.
- `layer_cnt`=1, out 10: no `ifmap_wren_o` at all; 10 results forwarded; `done_o` 1 cycle after the last beat.
- Early `fc_last_i` on beat 5 of N=10 (layer 0 of 2): `err_o`=1; COPY writes exactly 5 entries; layer 1 `fc_in_node_num_o`=5.
- `fc_valid_i` during COPY and `seq_start_i` during COLLECT: the beat is dropped with `err_o`=1; the start is ignored and the chain completes normally.
- `rst` asserted mid-COPY: all outputs 0 the same cycle; a new `seq_start_i` runs a full 2-layer chain correctly.
- Gapped input (valid every 3rd cycle), N=84: all 84 beats are captured, with no duplicate or missing pointer values.
